// File: rtl/i2s_sample_receiver.sv
// i2s_sample_receiver
// Deserializes the decoder's I2S output (SDOUT/BCLK/LRCK) into stereo frames,
// MSB first with the standard one-bit delay after LRCK, and queues completed
// {left, right} pairs in a small first-word-fallthrough FIFO.

module i2s_sample_receiver #(
  parameter int DATA_BITS       = 16,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     i2sData,
  input  logic                     i2sBitClk,
  input  logic                     i2sWordClk,
  input  logic                     fifoRead,
  output logic [2*DATA_BITS-1:0]   fifoRData,
  output logic                     fifoEmpty,
  output logic                     fifoFull,
  output logic [FIFO_DEPTH_LOG2:0] fifoLevel,
  output logic                     sampleStrobe,
  output logic                     overflow,
  output logic                     shortWord
);

  localparam int                       CountW     = $clog2(DATA_BITS + 1);
  localparam int                       Depth      = 1 << FIFO_DEPTH_LOG2;
  localparam logic [CountW-1:0]        FullCount  = CountW'(DATA_BITS);
  localparam logic [CountW-1:0]        CountOne   = CountW'(1);
  localparam logic [FIFO_DEPTH_LOG2:0] DepthLevel = (FIFO_DEPTH_LOG2 + 1)'(Depth);
  localparam logic [FIFO_DEPTH_LOG2:0] LevelOne   = (FIFO_DEPTH_LOG2 + 1)'(1);

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} rxState_t;

  // Pin conditioning
  logic [1:0] dataSync, bclkSync, wordSync;
  logic       bclkPrev;

  // Bit capture
  logic                 wPrev;
  logic [CountW-1:0]    count;
  logic [DATA_BITS-1:0] shiftReg;

  // Frame assembly
  rxState_t             state;
  logic [DATA_BITS-1:0] leftReg;
  logic                 leftValid;

  // FIFO storage
  logic [FIFO_DEPTH_LOG2-1:0] wrPtr, rdPtr;
  logic [2*DATA_BITS-1:0]     fifoMem [Depth];

  // Per-cycle decode
  logic                 bclkRise, d, w, wordChange, belowFull, closedValid;
  logic [DATA_BITS-1:0] closedWord;
  logic [CountW-1:0]    closedCount;
  logic                 pushReq, pushOk, popOk, dropEvent, shortEvent;

  assign bclkRise   = bclkSync[1] & ~bclkPrev;
  assign d          = dataSync[1];
  assign w          = wordSync[1];
  assign wordChange = bclkRise && (w != wPrev);
  assign belowFull  = count < FullCount;

  // Word that closes on an LRCK change: the delayed last bit is still appended
  // unless the slot already delivered all DATA_BITS bits.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    closedWord  = shiftReg;
    closedCount = count;
    if (belowFull) begin
      closedWord  = {shiftReg[DATA_BITS-2:0], d};
      closedCount = count + CountOne;
    end
  end

  assign closedValid = closedCount == FullCount;
  assign pushReq     = wordChange && enable && (state == RIGHT) && !w && closedValid && leftValid;
  assign shortEvent  = wordChange && enable && (state != SYNC) && !closedValid;
  assign popOk       = fifoRead && !fifoEmpty;
  assign pushOk      = pushReq && (!fifoFull || popOk);
  assign dropEvent   = pushReq && !pushOk;

  assign fifoEmpty = fifoLevel == '0;
  assign fifoFull  = fifoLevel == DepthLevel;
  // Gated so the head never shows stale or uninitialised storage while empty.
  assign fifoRData = fifoEmpty ? '0 : fifoMem[rdPtr];

  // Two-flop synchronizers on all three pins plus the BCLK edge history
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      dataSync <= '0;
      bclkSync <= '0;
      wordSync <= '0;
      bclkPrev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep each stage one clock behind the previous one.
      dataSync <= {dataSync[0], i2sData};
      bclkSync <= {bclkSync[0], i2sBitClk};
      wordSync <= {wordSync[0], i2sWordClk};
      bclkPrev <= bclkSync[1];
    end
  end

  // Shift register and saturating bit counter, advanced on each BCLK rise
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wPrev    <= 1'b0;
      count    <= '0;
      shiftReg <= '0;
    end else if (bclkRise) begin
      wPrev <= w;
      if (w != wPrev) begin
        count    <= '0;
        shiftReg <= '0;
      end else if (belowFull) begin
        count    <= count + CountOne;
        shiftReg <= {shiftReg[DATA_BITS-2:0], d};
      end
    end
  end

  // Channel state machine: align to a left-channel start, then pair words
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= SYNC;
      leftReg   <= '0;
      leftValid <= 1'b0;
    end else if (!enable) begin
      state     <= SYNC;
      leftValid <= 1'b0;
    end else if (wordChange) begin
      unique case (state)
        SYNC: if (!w) state <= LEFT;
        LEFT: if (w) begin
          leftReg   <= closedWord;
          leftValid <= closedValid;
          state     <= RIGHT;
        end
        RIGHT: if (!w) begin
          leftValid <= 1'b0;
          state     <= LEFT;
        end
        default: state <= SYNC;
      endcase
    end
  end

  // FIFO pointers, occupancy, push strobe and sticky status
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      fifoLevel    <= '0;
      sampleStrobe <= 1'b0;
      overflow     <= 1'b0;
      shortWord    <= 1'b0;
    end else begin
      sampleStrobe <= 1'b0;
      if (clear) begin
        wrPtr     <= '0;
        rdPtr     <= '0;
        fifoLevel <= '0;
        overflow  <= 1'b0;
        shortWord <= 1'b0;
      end else begin
        if (pushOk) begin
          wrPtr        <= wrPtr + 1'b1;
          sampleStrobe <= 1'b1;
        end
        if (popOk) rdPtr <= rdPtr + 1'b1;
        unique case ({pushOk, popOk})
          2'b10:   fifoLevel <= fifoLevel + LevelOne;
          2'b01:   fifoLevel <= fifoLevel - LevelOne;
          default: fifoLevel <= fifoLevel;
        endcase
        if (dropEvent)  overflow  <= 1'b1;
        if (shortEvent) shortWord <= 1'b1;
      end
    end
  end

  // Frame storage write port
  // NOTE: storage array has no reset; occupancy is tracked by the pointers and level alone.
  always_ff @(posedge clk) begin
    if (pushOk && !clear) fifoMem[wrPtr] <= {leftReg, closedWord};
  end

endmodule
